// File: rtl/seg7_serial_tx.sv
// Serialises a 64-bit, 8-digit segment pattern MSB first into an external
// shift-register chain, with a start/busy/done handshake and a queued restart.
module seg7_serial_tx #(
  parameter int DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] pattern,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        seg_clk,
  output logic        seg_sout,
  output logic        seg_clrn,
  output logic        seg_pen
);

  localparam logic [7:0] PHASE_MAX = 8'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    FINISH   = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [63:0] shadow, shadow_nx;
  logic [5:0]  bitcnt, bitcnt_nx;
  logic [7:0]  phase, phase_nx;
  logic        pending, pending_nx;
  logic        busy_nx, done_nx, clk_nx, sout_nx, pen_nx;
  logic        launch;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      bitcnt   <= 6'd0;
      phase    <= 8'd0;
      pending  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      seg_clk  <= 1'b0;
      seg_sout <= 1'b0;
      seg_clrn <= 1'b0;
      seg_pen  <= 1'b0;
    end else begin
      state    <= state_nx;
      bitcnt   <= bitcnt_nx;
      phase    <= phase_nx;
      pending  <= pending_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      seg_clk  <= clk_nx;
      seg_sout <= sout_nx;
      seg_clrn <= 1'b1;
      seg_pen  <= pen_nx;
    end
  end

  // Shadow copy of the frame is pure data and needs no reset.
  always_ff @(posedge clk) begin
    shadow <= shadow_nx;
  end

  always_comb begin
    state_nx   = state;
    shadow_nx  = shadow;
    bitcnt_nx  = bitcnt;
    phase_nx   = phase;
    pending_nx = pending;
    busy_nx    = busy;
    done_nx    = 1'b0;
    clk_nx     = seg_clk;
    sout_nx    = seg_sout;
    pen_nx     = seg_pen;
    launch     = 1'b0;

    case (state)
      IDLE: begin
        launch = start;
      end
      SHIFT_LO: begin
        if (start) pending_nx = 1'b1;
        if (phase == PHASE_MAX) begin
          phase_nx = 8'd0;
          clk_nx   = 1'b1;
          state_nx = SHIFT_HI;
        end else begin
          phase_nx = phase + 8'd1;
        end
      end
      SHIFT_HI: begin
        if (start) pending_nx = 1'b1;
        if (phase == PHASE_MAX) begin
          phase_nx = 8'd0;
          clk_nx   = 1'b0;
          if (bitcnt != 6'd63) begin
            // Next bit goes out on the falling edge so it is settled a full
            // half-period before the chain samples it.
            bitcnt_nx = bitcnt + 6'd1;
            shadow_nx = {shadow[62:0], 1'b0};
            sout_nx   = shadow[62];
            state_nx  = SHIFT_LO;
          end else begin
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            pen_nx   = 1'b1;
            state_nx = FINISH;
          end
        end else begin
          phase_nx = phase + 8'd1;
        end
      end
      FINISH: begin
        state_nx = IDLE;
        launch   = pending | start;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    if (launch) begin
      shadow_nx  = pattern;
      bitcnt_nx  = 6'd0;
      phase_nx   = 8'd0;
      pending_nx = 1'b0;
      busy_nx    = 1'b1;
      clk_nx     = 1'b0;
      sout_nx    = pattern[63];
      pen_nx     = 1'b0;
      state_nx   = SHIFT_LO;
    end
  end

endmodule

// File: tb/tb_seg7_serial_tx.sv
// Bench for seg7_serial_tx: scheduled/randomised stimulus on DIV=1,2,3 instances,
// checked cycle by cycle against a frame-level reference model.
module tb_seg7_serial_tx;

  localparam int MAXC   = 1024;
  localparam int B_BUSY = 5;
  localparam int B_DONE = 4;
  localparam int B_PEN  = 3;
  localparam int B_CLK  = 2;
  localparam int B_CLRN = 1;
  localparam int B_SOUT = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] pattern = '0;
  logic        start = 1'b0;
  logic [2:0]  busy_v, done_v, clk_v, sout_v, clrn_v, pen_v;

  int divs [3] = '{1, 2, 3};
  int sel = 0;
  int n_cmp = 0;
  int n_bad = 0;

  bit          st_sched  [0:MAXC];
  bit          rst_sched [0:MAXC];
  logic [63:0] pat_sched [0:MAXC];
  logic [5:0]  rec       [0:MAXC];
  logic [5:0]  exp_v     [0:MAXC];
  logic        got [$];
  int          dq  [$];

  always #5 clk = ~clk;

  seg7_serial_tx #(.DIV(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .pattern(pattern), .start(start),
    .busy(busy_v[0]), .done(done_v[0]), .seg_clk(clk_v[0]), .seg_sout(sout_v[0]),
    .seg_clrn(clrn_v[0]), .seg_pen(pen_v[0]));

  seg7_serial_tx #(.DIV(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .pattern(pattern), .start(start),
    .busy(busy_v[1]), .done(done_v[1]), .seg_clk(clk_v[1]), .seg_sout(sout_v[1]),
    .seg_clrn(clrn_v[1]), .seg_pen(pen_v[1]));

  seg7_serial_tx #(.DIV(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .pattern(pattern), .start(start),
    .busy(busy_v[2]), .done(done_v[2]), .seg_clk(clk_v[2]), .seg_sout(sout_v[2]),
    .seg_clrn(clrn_v[2]), .seg_pen(pen_v[2]));

  // Every scenario begins with reset held on cycles 0..2.
  task automatic clear_sched(input logic [63:0] p);
    for (int c = 0; c <= MAXC; c++) begin
      st_sched[c]  = 1'b0;
      rst_sched[c] = (c < 3);
      pat_sched[c] = p;
    end
  endtask

  // Frame-level model: a frame launched at edge fs owns cycles fs+1..fs+128d,
  // bit i is on the wire during its 2d-cycle slot, done follows on fs+128d+1.
  task automatic model(input int n);
    int d, fs, k, dcy, slot;
    bit pend, launch;
    logic [63:0] fp;
    logic so, pen, clrn, bz, dn, ck;
    d = divs[sel]; fs = -1; pend = 0; fp = '0; so = 0; pen = 0; clrn = 0;
    exp_v[0] = 'x;
    for (int c = 0; c < n; c++) begin
      k = c + 1;
      if (rst_sched[c]) begin
        fs = -1; pend = 0; so = 0; pen = 0; clrn = 0;
        exp_v[k] = 6'b0;
        continue;
      end
      clrn = 1; launch = 0;
      dcy = fs + 128 * d + 1;
      if (fs < 0 || c > dcy) launch = st_sched[c];
      else if (c == dcy)     launch = pend || st_sched[c];
      else                   pend = pend || st_sched[c];
      if (launch) begin fs = c; fp = pat_sched[c]; pend = 0; end
      bz = 0; dn = 0; ck = 0;
      if (fs >= 0 && k >= fs + 1 && k <= fs + 128 * d) begin
        slot = (k - fs - 1) / d;
        bz = 1; ck = (slot % 2) == 1; so = fp[63 - slot / 2]; pen = 0;
      end else if (fs >= 0 && k == fs + 128 * d + 1) begin
        dn = 1; pen = 1;
      end
      exp_v[k] = {bz, dn, pen, ck, clrn, so};
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c <= n; c++) begin
      rec[c] = {busy_v[sel], done_v[sel], pen_v[sel], clk_v[sel], clrn_v[sel], sout_v[sel]};
      rst_n   = !rst_sched[c];
      start   = st_sched[c];
      pattern = pat_sched[c];
      @(posedge clk); #1;
    end
    start = 1'b0;
    model(n);
  endtask

  task automatic collect(input int from, input int to);
    got.delete(); dq.delete();
    for (int c = from; c <= to; c++) begin
      if (rec[c][B_CLK] === 1'b1 && rec[c-1][B_CLK] === 1'b0) got.push_back(rec[c][B_SOUT]);
      if (rec[c][B_DONE] === 1'b1) dq.push_back(c);
    end
  endtask

  task automatic test_reset();
    sel = 1; clear_sched(64'h0); run(30);
    for (int c = 1; c <= 30; c++) begin
      n_cmp++;
      if (rec[c] !== exp_v[c]) begin
        n_bad++; $display("FAIL reset_model cycle %0d: got %b, want %b", c, rec[c], exp_v[c]);
      end
    end
    n_cmp++;
    if (rec[3][B_CLRN] !== 1'b0) begin n_bad++; $display("FAIL reset_clrn_low: got %b, want 0", rec[3][B_CLRN]); end
    n_cmp++;
    if (rec[4][B_CLRN] !== 1'b1) begin n_bad++; $display("FAIL reset_clrn_rise: got %b, want 1", rec[4][B_CLRN]); end
    for (int c = 4; c < 24; c++) begin
      n_cmp++;
      if ({rec[c][B_BUSY], rec[c][B_DONE], rec[c][B_PEN], rec[c][B_CLK]} !== 4'b0000) begin
        n_bad++; $display("FAIL reset_quiet cycle %0d: busy/done/pen/clk=%b, want 0000", c, rec[c][5:2]);
      end
    end
  endtask

  task automatic test_single_frame();
    int s = 5, first = -1, last = -1, cnt = 0;
    sel = 1; clear_sched(64'h8000_0000_0000_0001); st_sched[s] = 1; run(s + 270);
    for (int c = 1; c <= s + 270; c++) begin
      n_cmp++;
      if (rec[c] !== exp_v[c]) begin
        n_bad++; $display("FAIL single_model cycle %0d: got %b, want %b", c, rec[c], exp_v[c]);
      end
      if (rec[c][B_BUSY] === 1'b1) begin if (first < 0) first = c; last = c; cnt++; end
    end
    n_cmp++;
    if (first !== s + 1 || last !== s + 256 || cnt !== 256) begin
      n_bad++; $display("FAIL single_busy: first %0d last %0d count %0d, want %0d %0d 256", first, last, cnt, s + 1, s + 256);
    end
    collect(4, s + 270);
    n_cmp++;
    if (dq.size() !== 1 || dq[0] !== s + 257) begin
      n_bad++; $display("FAIL single_done: %0d pulses first at %0d, want 1 at %0d", dq.size(), (dq.size() > 0) ? dq[0] : -1, s + 257);
    end
    n_cmp++;
    if (got.size() !== 64) begin n_bad++; $display("FAIL single_rises: got %0d, want 64", got.size()); end
    for (int i = 0; i < got.size() && i < 64; i++) begin
      n_cmp++;
      if (got[i] !== ((i == 0 || i == 63) ? 1'b1 : 1'b0)) begin
        n_bad++; $display("FAIL single_bit %0d: got %b, want %b", i, got[i], (i == 0 || i == 63));
      end
    end
    for (int c = s + 257; c <= s + 270; c++) begin
      n_cmp++;
      if (rec[c][B_PEN] !== 1'b1) begin n_bad++; $display("FAIL single_pen cycle %0d: got %b, want 1", c, rec[c][B_PEN]); end
    end
  endtask

  task automatic test_pattern_change();
    int s = 5;
    sel = 0; clear_sched(64'hFFFF_FFFF_0000_0000);
    for (int c = s + 10; c <= MAXC; c++) pat_sched[c] = 64'h0;
    st_sched[s] = 1; run(s + 140);
    for (int c = 1; c <= s + 140; c++) begin
      n_cmp++;
      if (rec[c] !== exp_v[c]) begin
        n_bad++; $display("FAIL patchg_model cycle %0d: got %b, want %b", c, rec[c], exp_v[c]);
      end
    end
    collect(4, s + 140);
    n_cmp++;
    if (got.size() !== 64) begin n_bad++; $display("FAIL patchg_rises: got %0d, want 64", got.size()); end
    for (int i = 0; i < got.size() && i < 64; i++) begin
      n_cmp++;
      if (got[i] !== (i < 32)) begin n_bad++; $display("FAIL patchg_bit %0d: got %b, want %b", i, got[i], (i < 32)); end
    end
  endtask

  task automatic test_queued_start();
    int s = 5, cnt = 0;
    logic [63:0] p2;
    sel = 0; clear_sched(64'h0);
    for (int c = 0; c <= MAXC; c++) pat_sched[c] = {$urandom, $urandom};
    st_sched[s] = 1; st_sched[s + 30] = 1; st_sched[s + 60] = 1;
    p2 = pat_sched[s + 129];
    run(s + 280);
    for (int c = 1; c <= s + 280; c++) begin
      n_cmp++;
      if (rec[c] !== exp_v[c]) begin
        n_bad++; $display("FAIL queued_model cycle %0d: got %b, want %b", c, rec[c], exp_v[c]);
      end
      if (c >= s + 130 && rec[c][B_BUSY] === 1'b1) cnt++;
    end
    collect(4, s + 280);
    n_cmp++;
    if (dq.size() !== 2 || dq[0] !== s + 129 || dq[1] !== s + 258) begin
      n_bad++; $display("FAIL queued_done: %0d pulses, want 2 at %0d and %0d", dq.size(), s + 129, s + 258);
    end
    n_cmp++;
    if (cnt !== 128 || rec[s + 130][B_BUSY] !== 1'b1 || rec[s + 257][B_BUSY] !== 1'b1) begin
      n_bad++; $display("FAIL queued_busy2: count %0d, want 128 on cycles %0d..%0d", cnt, s + 130, s + 257);
    end
    n_cmp++;
    if (got.size() !== 128) begin n_bad++; $display("FAIL queued_rises: got %0d, want 128", got.size()); end
    for (int i = 64; i < got.size() && i < 128; i++) begin
      n_cmp++;
      if (got[i] !== p2[127 - i]) begin n_bad++; $display("FAIL queued_bit2 %0d: got %b, want %b", i - 64, got[i], p2[127 - i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int s = 5, r = 105, s2 = 115, n = 505;
    logic [63:0] p2;
    p2 = {$urandom, $urandom};
    sel = 2; clear_sched({$urandom, $urandom});
    for (int c = s2; c <= MAXC; c++) pat_sched[c] = p2;
    st_sched[s] = 1; rst_sched[r] = 1; st_sched[s2] = 1;
    run(n);
    for (int c = 1; c <= n; c++) begin
      n_cmp++;
      if (rec[c] !== exp_v[c]) begin
        n_bad++; $display("FAIL rstmid_model cycle %0d: got %b, want %b", c, rec[c], exp_v[c]);
      end
    end
    n_cmp++;
    if ({rec[r + 1][B_BUSY], rec[r + 1][B_CLRN], rec[r + 1][B_PEN], rec[r + 1][B_DONE]} !== 4'b0000) begin
      n_bad++; $display("FAIL rstmid_abort: busy/clrn/pen/done=%b, want 0000", {rec[r + 1][B_BUSY], rec[r + 1][B_CLRN], rec[r + 1][B_PEN], rec[r + 1][B_DONE]});
    end
    collect(4, s2);
    n_cmp++;
    if (dq.size() !== 0) begin n_bad++; $display("FAIL rstmid_nodone: got %0d pulses, want 0", dq.size()); end
    collect(s2 + 1, n);
    n_cmp++;
    if (dq.size() !== 1 || dq[0] !== s2 + 385) begin
      n_bad++; $display("FAIL rstmid_done2: %0d pulses, want 1 at %0d", dq.size(), s2 + 385);
    end
    n_cmp++;
    if (got.size() !== 64) begin n_bad++; $display("FAIL rstmid_rises: got %0d, want 64", got.size()); end
    for (int i = 0; i < got.size() && i < 64; i++) begin
      n_cmp++;
      if (got[i] !== p2[63 - i]) begin n_bad++; $display("FAIL rstmid_bit %0d: got %b, want %b", i, got[i], p2[63 - i]); end
    end
  endtask

  task automatic test_back_to_back();
    int s = 5, n = 405;
    logic [63:0] p = 64'h0123_4567_89AB_CDEF;
    logic want;
    sel = 0; clear_sched(p);
    for (int c = s; c <= s + 258; c++) st_sched[c] = 1;
    run(n);
    for (int c = 1; c <= n; c++) begin
      n_cmp++;
      if (rec[c] !== exp_v[c]) begin
        n_bad++; $display("FAIL b2b_model cycle %0d: got %b, want %b", c, rec[c], exp_v[c]);
      end
    end
    collect(4, n);
    n_cmp++;
    if (dq.size() !== 3 || dq[0] !== s + 129 || dq[1] !== s + 258 || dq[2] !== s + 387) begin
      n_bad++; $display("FAIL b2b_done: %0d pulses, want 3 at %0d %0d %0d", dq.size(), s + 129, s + 258, s + 387);
    end
    for (int c = s + 1; c <= s + 387; c++) begin
      want = !((c - s) % 129 == 0);
      n_cmp++;
      if (rec[c][B_BUSY] !== want) begin n_bad++; $display("FAIL b2b_busy cycle %0d: got %b, want %b", c, rec[c][B_BUSY], want); end
    end
    n_cmp++;
    if (got.size() !== 192) begin n_bad++; $display("FAIL b2b_rises: got %0d, want 192", got.size()); end
    for (int i = 0; i < got.size() && i < 192; i++) begin
      n_cmp++;
      if (got[i] !== p[63 - (i % 64)]) begin n_bad++; $display("FAIL b2b_bit %0d: got %b, want %b", i, got[i], p[63 - (i % 64)]); end
    end
  endtask

  task automatic test_random();
    int n = 900;
    for (int it = 0; it < 3; it++) begin
      sel = $urandom_range(0, 2);
      clear_sched({$urandom, $urandom});
      for (int c = 3; c <= n; c++) begin
        st_sched[c]  = ($urandom_range(0, 99) < 3);
        rst_sched[c] = ($urandom_range(0, 599) == 0);
        pat_sched[c] = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : pat_sched[c - 1];
      end
      run(n);
      for (int c = 1; c <= n; c++) begin
        n_cmp++;
        if (rec[c] !== exp_v[c]) begin
          n_bad++; $display("FAIL random%0d_model div %0d cycle %0d: got %b, want %b", it, divs[sel], c, rec[c], exp_v[c]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_pattern_change();
    test_queued_start();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_serial_tx.md
# seg7_serial_tx

Parallel-to-serial transmitter that takes the 64-bit segment pattern from the 8-digit 7-segment decoder and shifts it into the board's external segment shift-register chain. Eight bytes, one per digit with the point bit in bit 7 and active-low segments, are already formatted upstream, so this block performs no bit remapping. It produces the serial clock, data, clear and display-enable pins, and offers a start/busy/done handshake to the top-level display refresher.

## Interface
- `DIV`, default 4: system-clock cycles per serial-clock half-period; legal values are 1 to 255.
- `clk` input, 1 bit: system clock; all logic runs on the rising edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `pattern` input, 64 bits: segment pattern, with byte i driving digit i. The block samples it only at frame start.
- `start` input, 1 bit: request to transmit one frame, level-sampled every cycle.
- `busy` output, 1 bit: high while a frame is shifting.
- `done` output, 1 bit: one-cycle pulse when a frame has finished.
- `seg_clk` output, 1 bit: serial clock; the external chain samples `seg_sout` on the rising edge.
- `seg_sout` output, 1 bit: serial data.
- `seg_clrn` output, 1 bit: active-low clear of the external chain.
- `seg_pen` output, 1 bit: display enable, active high.

## Operation
- **States.**
  - IDLE
  - SHIFT_LO: `seg_clk`=0
  - SHIFT_HI: `seg_clk`=1
  - FINISH
- **Reset values**, held while `rst_n`=0 and for the cycle after it is sampled low:
  - state IDLE
  - `busy`=0, `done`=0
  - `seg_clk`=0, `seg_sout`=0
  - `seg_clrn`=0
  - `seg_pen`=0
  - bit counter 0, phase counter 0, pending 0
- **After reset.** `seg_clrn` goes to 1 on the first non-reset cycle and stays 1. `seg_pen` stays 0 until the first frame completes, so power-up contents of the external chain are never displayed.
- **IDLE, start=1.**
  - Copy `pattern` into a 64-bit shadow register.
  - Set bit counter = 0 and go to SHIFT_LO.
  - `seg_sout` = `pattern[63]`, `seg_pen`=0, `busy`=1.
- **SHIFT_LO.** Hold for DIV cycles, then go to SHIFT_HI.
- **SHIFT_HI.**
  - Hold for DIV cycles.
  - At exit, if bit counter < 63: increment it, shift the shadow register left, put the next bit on `seg_sout`, and go to SHIFT_LO.
  - If bit counter = 63: go to FINISH.
- **Bit order.** MSB first: `pattern[63]` first and `pattern[0]` last.
- **Data stability.** `seg_sout` changes only on entry to SHIFT_LO, so it is stable for the whole high phase.
- **FINISH**, which lasts exactly one cycle:
  - `done`=1, `busy`=0, `seg_pen`=1, `seg_clk`=0.
  - `seg_sout` keeps its last value.
- **Leaving FINISH.**
  - If pending=1 or start=1: capture `pattern` fresh at this edge, clear pending, and go to SHIFT_LO as from IDLE.
  - Otherwise go to IDLE.
- **start while busy.** Sets pending; multiple requests collapse into one. The frame in progress is not disturbed, and `pattern` changes mid-frame are ignored.
- **Back-to-back frames.** `seg_pen` stays 1 in IDLE. It drops to 0 on the cycle a new frame begins.
- **Reset mid-frame.** Aborts immediately to the reset values, with no `done` pulse. The chain is cleared by `seg_clrn`=0 and `seg_pen` goes low.
- **Counters.** The phase counter is 8 bits and compares against DIV−1. The bit counter is 6 bits and never wraps past 63 within a frame.

## Timing
- **Frame timing**, with the start edge taken as cycle 0 (IDLE with start=1 sampled):
  - `busy` is high on cycles 1 through 128·DIV.
  - `done` is high on cycle 128·DIV+1 only.
  - The earliest possible next `busy` is cycle 128·DIV+2.
- **Serial clock.**
  - `seg_clk` has period 2·DIV cycles and 50 % duty.
  - There are exactly 64 rising edges per frame.
  - Rising edge n (0-based) occurs at cycle 1+(2n+1)·DIV.
- **Output timing.** All outputs are registered. `seg_sout` leads each `seg_clk` rise by DIV cycles and holds for DIV cycles after it.
- **Handshake.** The `start` to first `busy` latency is 1 cycle. A start that arrives in FINISH, or while pending, gives zero idle cycles between frames.

## Test plan
- **Reset.** Hold `rst_n`=0 for 3 cycles, then release with start=0.
  - Required: `seg_clrn` 0→1 on the first cycle after release.
  - Required: `seg_pen`, `seg_clk`, `busy`, `done` all stay 0 for 20 cycles.
- **Single frame**, DIV=2, pattern=0x8000_0000_0000_0001, start pulsed once.
  - Required: `busy` high on cycles 1–256 and `done` on cycle 257 only.
  - Required: 64 `seg_clk` rises. A sampled `seg_sout` stream of 1, then 62 zeros, then 1.
  - Required: `seg_pen` = 0 during the frame and 1 from cycle 257 on.
- **Pattern change mid-frame.** DIV=1, pattern=0xFFFF_FFFF_0000_0000 at start, changed to 0 at cycle 10.
  - Required: the captured stream is 32 ones then 32 zeros.
- **Queued start.** DIV=1, start pulsed at cycles 0, 30 and 60.
  - Required: two frames only, `done` at cycle 129, second frame `busy` on cycles 130–257.
  - Required: the second frame carries the `pattern` value present at cycle 129.
- **Reset mid-frame.** DIV=3, `rst_n`=0 at cycle 100 of a frame.
  - Required: on the next cycle `busy`=0, `seg_clrn`=0, `seg_pen`=0, with no `done` pulse.
  - Required: a subsequent start sends a complete 64-bit frame.
- **Continuous start.** DIV=1, start held high for 3 frames, pattern fixed at 0x0123_4567_89AB_CDEF.
  - Required: `done` at cycles 129, 258 and 387.
  - Required: `busy` low only on the `done` cycles.
  - Required: each frame's stream equals the pattern, MSB first.
